// File: rtl/dual_port_ram_be.sv
// Simple-dual-port RAM with per-byte write enables, a 1..3 stage registered read path,
// selectable read-during-write behaviour, and collision / out-of-range reporting.
module dual_port_ram_be #(
   parameter int MEMORY_DATA_WIDTH = 32,
   parameter int ADDR_WIDTH        = 10,
   parameter int DEPTH             = 1 << ADDR_WIDTH,
   parameter int BYTE_WIDTH        = 8,
   parameter int RD_LATENCY        = 1,
   parameter int RDW_MODE          = 0,
   parameter int CLEAR_ON_IDLE     = 1,
   localparam int NUM_BYTES        = MEMORY_DATA_WIDTH / BYTE_WIDTH
) (
   input  logic                         RAM_clk,
   input  logic                         RAM_rst,
   input  logic                         RAM_en,
   input  logic                         RAM_wr_en,
   input  logic [ADDR_WIDTH-1:0]        RAM_wr_addr,
   input  logic [MEMORY_DATA_WIDTH-1:0] RAM_wr_data,
   input  logic [NUM_BYTES-1:0]         RAM_wr_be,
   input  logic                         RAM_rd_en,
   input  logic [ADDR_WIDTH-1:0]        RAM_rd_addr,
   output logic [MEMORY_DATA_WIDTH-1:0] RAM_rd_data,
   output logic                         RAM_rd_valid,
   output logic                         RAM_collision,
   output logic                         RAM_addr_err
);

   typedef logic [MEMORY_DATA_WIDTH-1:0] word_t;

   // One extra bit so DEPTH == 2**ADDR_WIDTH stays representable.
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

   function automatic word_t merge_lanes(input word_t                old_w,
                                         input word_t                new_w,
                                         input logic [NUM_BYTES-1:0] be);
      word_t m;
      m = old_w;
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (be[i]) m[i*BYTE_WIDTH +: BYTE_WIDTH] = new_w[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
      return m;
   endfunction

   word_t mem_q [DEPTH];

   logic wr_req, rd_req;
   logic wr_in_range, rd_in_range;
   logic wr_ok, rd_ok, same_addr;
   word_t rd_word, stage1_word;

   word_t                 data_d [RD_LATENCY];
   word_t                 data_q [RD_LATENCY];
   logic [RD_LATENCY-1:0] vld_d, vld_q;
   logic [RD_LATENCY-1:0] col_d, col_q;
   logic                  addr_err_d, addr_err_q;

   always_comb begin
      wr_req      = RAM_en & RAM_wr_en & ~RAM_rst;
      rd_req      = RAM_en & RAM_rd_en & ~RAM_rst;
      wr_in_range = ({1'b0, RAM_wr_addr} < DEPTH_W);
      rd_in_range = ({1'b0, RAM_rd_addr} < DEPTH_W);
      wr_ok       = wr_req & wr_in_range;
      rd_ok       = rd_req & rd_in_range;
      same_addr   = (RAM_wr_addr == RAM_rd_addr);
   end

   // Array write: only enabled lanes of an in-range word change.
   always_ff @(posedge RAM_clk) begin
      if (wr_ok) begin
         for (int i = 0; i < NUM_BYTES; i++) begin
            if (RAM_wr_be[i]) begin
               mem_q[RAM_wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                  RAM_wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   // Stage 1: array read, with write-first merge on a same-address collision.
   always_comb begin
      rd_word     = '0;
      stage1_word = '0;
      if (rd_in_range) begin
         rd_word     = mem_q[RAM_rd_addr];
         stage1_word = rd_word;
         if (RDW_MODE == 1 && wr_ok && same_addr) begin
            stage1_word = merge_lanes(rd_word, RAM_wr_data, RAM_wr_be);
         end
      end
   end

   // Data registers load only with a valid word so the output can hold between reads.
   always_comb begin
      vld_d[0]  = rd_req;
      col_d[0]  = rd_ok & wr_ok & same_addr;
      data_d[0] = rd_req ? stage1_word : data_q[0];
      for (int s = 1; s < RD_LATENCY; s++) begin
         vld_d[s]  = vld_q[s-1];
         col_d[s]  = col_q[s-1];
         data_d[s] = vld_q[s-1] ? data_q[s-1] : data_q[s];
      end
      addr_err_d = (wr_req & ~wr_in_range) | (rd_req & ~rd_in_range);
   end

   always_ff @(posedge RAM_clk) begin
      if (RAM_rst) begin
         vld_q      <= '0;
         col_q      <= '0;
         addr_err_q <= 1'b0;
         for (int s = 0; s < RD_LATENCY; s++) data_q[s] <= '0;
      end else begin
         vld_q      <= vld_d;
         col_q      <= col_d;
         addr_err_q <= addr_err_d;
         for (int s = 0; s < RD_LATENCY; s++) data_q[s] <= data_d[s];
      end
   end

   always_comb begin
      RAM_rd_valid  = vld_q[RD_LATENCY-1];
      RAM_collision = col_q[RD_LATENCY-1];
      RAM_addr_err  = addr_err_q;
      RAM_rd_data   = data_q[RD_LATENCY-1];
      if (CLEAR_ON_IDLE != 0 && !vld_q[RD_LATENCY-1]) RAM_rd_data = '0;
   end

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Scoreboard bench for dual_port_ram_be: three instances (read-first, write-first,
// 3-stage latency with DEPTH=600 and held idle output) exercised one after another.
module tb_dual_port_ram_be;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst [3];
   logic        en  [3];
   logic        we  [3];
   logic        re  [3];
   logic [9:0]  wa  [3];
   logic [9:0]  ra  [3];
   logic [31:0] wd  [3];
   logic [3:0]  be  [3];
   logic [31:0] rd_o   [3];
   logic        vld_o  [3];
   logic        coll_o [3];
   logic        err_o  [3];

   int lat [3] = '{1, 1, 3};

   typedef struct {
      int          dut;
      int          due;
      logic [31:0] data;
      logic        coll;
   } rexp_t;

   typedef struct {
      int dut;
      int due;
   } eexp_t;

   rexp_t rq[$];
   eexp_t eq[$];

   logic armed = 1'b0;
   logic done  = 1'b0;
   int   n_vec  = 0;
   int   n_fail = 0;
   logic [31:0] last [3] = '{32'h0, 32'h0, 32'h0};

   dual_port_ram_be #(.RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_IDLE(1)) u_rf (
      .RAM_clk(clk), .RAM_rst(rst[0]), .RAM_en(en[0]), .RAM_wr_en(we[0]),
      .RAM_wr_addr(wa[0]), .RAM_wr_data(wd[0]), .RAM_wr_be(be[0]),
      .RAM_rd_en(re[0]), .RAM_rd_addr(ra[0]), .RAM_rd_data(rd_o[0]),
      .RAM_rd_valid(vld_o[0]), .RAM_collision(coll_o[0]), .RAM_addr_err(err_o[0]));

   dual_port_ram_be #(.RD_LATENCY(1), .RDW_MODE(1), .CLEAR_ON_IDLE(1)) u_wf (
      .RAM_clk(clk), .RAM_rst(rst[1]), .RAM_en(en[1]), .RAM_wr_en(we[1]),
      .RAM_wr_addr(wa[1]), .RAM_wr_data(wd[1]), .RAM_wr_be(be[1]),
      .RAM_rd_en(re[1]), .RAM_rd_addr(ra[1]), .RAM_rd_data(rd_o[1]),
      .RAM_rd_valid(vld_o[1]), .RAM_collision(coll_o[1]), .RAM_addr_err(err_o[1]));

   dual_port_ram_be #(.ADDR_WIDTH(10), .DEPTH(600), .RD_LATENCY(3), .RDW_MODE(0),
                      .CLEAR_ON_IDLE(0)) u_l3 (
      .RAM_clk(clk), .RAM_rst(rst[2]), .RAM_en(en[2]), .RAM_wr_en(we[2]),
      .RAM_wr_addr(wa[2]), .RAM_wr_data(wd[2]), .RAM_wr_be(be[2]),
      .RAM_rd_en(re[2]), .RAM_rd_addr(ra[2]), .RAM_rd_data(rd_o[2]),
      .RAM_rd_valid(vld_o[2]), .RAM_collision(coll_o[2]), .RAM_addr_err(err_o[2]));

   // One clocked operation on instance k; expectations are queued before the edge.
   task automatic op(input int k, input logic e, input logic w, input logic [9:0] wa_i,
                     input logic [31:0] wd_i, input logic [3:0] be_i, input logic r,
                     input logic [9:0] ra_i, input logic xv, input logic [31:0] xd,
                     input logic xc, input logic xe);
      rexp_t rx;
      eexp_t ex;
      en[k] = e; we[k] = w; wa[k] = wa_i; wd[k] = wd_i; be[k] = be_i;
      re[k] = r; ra[k] = ra_i;
      if (xv) begin
         rx.dut = k; rx.due = cyc + lat[k]; rx.data = xd; rx.coll = xc;
         rq.push_back(rx);
      end
      if (xe) begin
         ex.dut = k; ex.due = cyc + 1;
         eq.push_back(ex);
      end
      @(posedge clk); #1;
      en[k] = 1'b1; we[k] = 1'b0; re[k] = 1'b0;
   endtask

   task automatic wr(input int k, input logic [9:0] a, input logic [31:0] d, input logic [3:0] b);
      op(k, 1'b1, 1'b1, a, d, b, 1'b0, 10'd0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic rd(input int k, input logic [9:0] a, input logic [31:0] xd);
      op(k, 1'b1, 1'b0, 10'd0, 32'h0, 4'h0, 1'b1, a, 1'b1, xd, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic reset_pulse(input int k);
      rst[k] = 1'b1;
      @(posedge clk); #1;
      rst[k] = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1; en[k] = 1'b0; we[k] = 1'b0; re[k] = 1'b0;
         wa[k] = '0; ra[k] = '0; wd[k] = '0; be[k] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b0; en[k] = 1'b1;
      end
      armed = 1'b1;
      idle(2);

      // Read-first instance: full write, partial write, collision, unrelated addresses.
      wr(0, 10'd5, 32'hDEADBEEF, 4'hF);
      rd(0, 10'd5, 32'hDEADBEEF);
      wr(0, 10'd3, 32'h11223344, 4'hF);
      wr(0, 10'd3, 32'hAABBCCDD, 4'b0101);
      rd(0, 10'd3, 32'h11BB33DD);
      wr(0, 10'd7, 32'h00000000, 4'hF);
      op(0, 1'b1, 1'b1, 10'd7, 32'hFFFFFFFF, 4'b0011, 1'b1, 10'd7, 1'b1, 32'h00000000, 1'b1, 1'b0);
      rd(0, 10'd7, 32'h0000FFFF);
      op(0, 1'b1, 1'b1, 10'd6, 32'h55555555, 4'hF, 1'b1, 10'd5, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
      wr(0, 10'd5, 32'hFFFFFFFF, 4'h0);
      rd(0, 10'd5, 32'hDEADBEEF);
      rd(0, 10'd6, 32'h55555555);
      idle(3);

      // Write-first instance.
      wr(1, 10'd7, 32'h00000000, 4'hF);
      op(1, 1'b1, 1'b1, 10'd7, 32'hFFFFFFFF, 4'b0011, 1'b1, 10'd7, 1'b1, 32'h0000FFFF, 1'b1, 1'b0);
      rd(1, 10'd7, 32'h0000FFFF);
      wr(1, 10'd9, 32'h11223344, 4'hF);
      op(1, 1'b1, 1'b1, 10'd9, 32'hAABBCCDD, 4'b1000, 1'b1, 10'd9, 1'b1, 32'hAA223344, 1'b1, 1'b0);
      rd(1, 10'd9, 32'hAA223344);
      idle(3);

      // Three-stage instance: streaming, bubbles, reset with reads in flight.
      wr(2, 10'd0, 32'h0000000A, 4'hF);
      wr(2, 10'd1, 32'h0000000B, 4'hF);
      wr(2, 10'd2, 32'h0000000C, 4'hF);
      rd(2, 10'd0, 32'h0000000A);
      rd(2, 10'd1, 32'h0000000B);
      rd(2, 10'd2, 32'h0000000C);
      idle(4);
      rd(2, 10'd0, 32'h0000000A);
      op(2, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd1, 1'b0, 32'h0, 1'b0, 1'b0);
      rd(2, 10'd2, 32'h0000000C);
      idle(4);
      op(2, 1'b1, 1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd0, 1'b0, 32'h0, 1'b0, 1'b0);
      op(2, 1'b1, 1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd1, 1'b0, 32'h0, 1'b0, 1'b0);
      reset_pulse(2);
      rd(2, 10'd2, 32'h0000000C);
      idle(4);

      // Out-of-range accesses and a disabled cycle.
      op(2, 1'b1, 1'b1, 10'd700, 32'h12345678, 4'hF, 1'b0, 10'd0, 1'b0, 32'h0, 1'b0, 1'b1);
      rd(2, 10'd0, 32'h0000000A);
      rd(2, 10'd1, 32'h0000000B);
      rd(2, 10'd2, 32'h0000000C);
      op(2, 1'b1, 1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd700, 1'b1, 32'h0, 1'b0, 1'b1);
      idle(4);
      op(2, 1'b1, 1'b1, 10'd700, 32'hFFFFFFFF, 4'hF, 1'b1, 10'd700, 1'b1, 32'h0, 1'b0, 1'b1);
      idle(4);
      op(2, 1'b0, 1'b1, 10'd1, 32'hFFFFFFFF, 4'hF, 1'b1, 10'd1, 1'b0, 32'h0, 1'b0, 1'b0);
      rd(2, 10'd1, 32'h0000000B);
      idle(6);
      done = 1'b1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   always @(negedge clk) begin
      rexp_t rx;
      logic  exp_e;
      if (armed) begin
         for (int k = 0; k < 3; k++) begin
            if (vld_o[k] === 1'b1) begin
               n_vec++;
               if (rq.size() == 0 || rq[0].dut != k) begin
                  n_fail++;
                  $display("FAIL unexpected_valid dut%0d cyc %0d: got data %h, required no valid",
                           k, cyc, rd_o[k]);
               end else begin
                  rx = rq.pop_front();
                  if (rx.due != cyc || rd_o[k] !== rx.data || coll_o[k] !== rx.coll) begin
                     n_fail++;
                     $display("FAIL read dut%0d: got cyc %0d data %h coll %b, required cyc %0d data %h coll %b",
                              k, cyc, rd_o[k], coll_o[k], rx.due, rx.data, rx.coll);
                  end
               end
               last[k] = rd_o[k];
            end else begin
               n_vec++;
               if (vld_o[k] !== 1'b0 || coll_o[k] !== 1'b0 ||
                   rd_o[k] !== ((k == 2) ? last[k] : 32'h0)) begin
                  n_fail++;
                  $display("FAIL idle dut%0d cyc %0d: got vld %b coll %b data %h, required 0 0 %h",
                           k, cyc, vld_o[k], coll_o[k], rd_o[k], (k == 2) ? last[k] : 32'h0);
               end
               if (rq.size() > 0 && rq[0].dut == k && rq[0].due <= cyc) begin
                  n_vec++;
                  n_fail++;
                  rx = rq.pop_front();
                  $display("FAIL missing_valid dut%0d: got none by cyc %0d, required data %h at cyc %0d",
                           k, cyc, rx.data, rx.due);
               end
            end
            exp_e = (eq.size() > 0 && eq[0].dut == k && eq[0].due == cyc);
            if (exp_e || err_o[k] !== 1'b0) begin
               n_vec++;
               if (err_o[k] !== exp_e) begin
                  n_fail++;
                  $display("FAIL addr_err dut%0d cyc %0d: got %b, required %b", k, cyc, err_o[k], exp_e);
               end
               if (exp_e) void'(eq.pop_front());
            end
            if (rst[k]) last[k] = 32'h0;
         end
         if (done) begin
            n_vec++;
            if (rq.size() != 0 || eq.size() != 0) begin
               n_fail++;
               $display("FAIL pending_expectations: got %0d reads and %0d errors outstanding, required 0 and 0",
                        rq.size(), eq.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
            $finish;
         end
      end
   end

endmodule

// File: doc/dual_port_ram_be.md
Name: dual_port_ram_be

Overview:
- Parametrised simple-dual-port RAM: one write port, one read port, one clock.
- Successor of the team's basic dual-port RAM, with these additions:
  - per-byte write enables
  - configurable read latency (1-3 registered stages)
  - selectable read-during-write mode
  - read-valid output, collision flag and out-of-range address error flag
- Used as storage behind FIFOs and packet buffers where partial-word writes and timing-closure pipeline stages are needed.

Parameters:
- MEMORY_DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 10, address width.
- DEPTH, 1<<ADDR_WIDTH, number of words; must be <= 2^ADDR_WIDTH.
- BYTE_WIDTH, 8, bits per write-enable lane; NUM_BYTES = MEMORY_DATA_WIDTH/BYTE_WIDTH (derived).
- RD_LATENCY, 1, cycles from accepted read to data; legal values 1..3.
- RDW_MODE, 0, same-address read+write in one cycle: 0 = read-first (old data), 1 = write-first (merged new data).
- CLEAR_ON_IDLE, 1, when 1, RAM_rd_data is forced to zero whenever RAM_rd_valid is 0; when 0, it holds its last value.

Ports:
- RAM_clk  input  1  clock; all logic on the rising edge.
- RAM_rst  input  1  synchronous, active-high reset.
- RAM_en  input  1  global enable; when 0, both ports are treated as idle.
- RAM_wr_en  input  1  write request.
- RAM_wr_addr  input  ADDR_WIDTH  write address.
- RAM_wr_data  input  MEMORY_DATA_WIDTH  write data.
- RAM_wr_be  input  NUM_BYTES  byte enables; bit i covers data[i*BYTE_WIDTH +: BYTE_WIDTH].
- RAM_rd_en  input  1  read request.
- RAM_rd_addr  input  ADDR_WIDTH  read address.
- RAM_rd_data  output  MEMORY_DATA_WIDTH  read data, aligned with RAM_rd_valid.
- RAM_rd_valid  output  1  RAM_rd_data holds the result of a read.
- RAM_collision  output  1  pulses, aligned with RAM_rd_valid, for a read that coincided with a same-address write.
- RAM_addr_err  output  1  one-cycle pulse, the cycle after any accepted access with address >= DEPTH.

Behaviour:
- Effective requests: wr = RAM_en & RAM_wr_en & !RAM_rst; rd = RAM_en & RAM_rd_en & !RAM_rst.
- Reset:
  - RAM_rd_data, RAM_rd_valid, RAM_collision, RAM_addr_err and all pipeline stages go to 0.
  - Memory contents are not reset; words never written read as X in simulation.
  - Writes are blocked while RAM_rst = 1.
- Write:
  - On the edge where wr = 1 and address < DEPTH, each byte lane with RAM_wr_be[i] = 1 is updated.
  - Other lanes keep their contents.
  - wr with RAM_wr_be = 0 is a legal no-op (no error).
- Read latency:
  - A read accepted at edge T produces RAM_rd_valid = 1 with data, visible after edge T+RD_LATENCY.
  - Stage 1 is the array read register; stages 2..RD_LATENCY are plain pipeline registers with a valid bit.
  - Back-to-back reads give back-to-back valid cycles; throughput is 1 word/cycle.
  - The pipeline has no stall input; RAM_en = 0 inserts bubbles and in-flight data keeps advancing.
- Read-during-write, same in-range address in the same cycle:
  - RDW_MODE = 0: returns the pre-write word.
  - RDW_MODE = 1: returns enabled lanes from RAM_wr_data and the remaining lanes from the old word.
  - In both modes RAM_collision = 1 travels with that read's valid.
  - Different addresses: no interaction.
- Out of range (address >= DEPTH; only possible when DEPTH < 2^ADDR_WIDTH):
  - Write is dropped.
  - Read still produces valid, with data = 0 and RAM_collision = 0.
  - RAM_addr_err pulses one cycle after the access edge; simultaneous read and write errors give a single pulse.
- Idle output:
  - CLEAR_ON_IDLE = 1: RAM_rd_data = 0 whenever valid = 0.
  - CLEAR_ON_IDLE = 0: data holds its last value.
- Reset mid-operation: all in-flight reads are discarded, no valid is emitted for them, and the first valid after reset is from a read accepted after reset deasserts.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 5 (be = 4'hF); read addr 5 with RD_LATENCY = 1 -> valid and data 0xDEADBEEF one cycle after the read edge; data = 0 in all other cycles (CLEAR_ON_IDLE = 1).
- Write 0x11223344 to addr 3; then write 0xAABBCCDD with be = 4'b0101; read addr 3 -> 0x11BB33DD.
- With addr 7 holding 0x00000000, read and write 0xFFFFFFFF (be = 4'b0011) to addr 7 in the same cycle:
  - RDW_MODE = 0 -> 0x00000000 with RAM_collision = 1.
  - RDW_MODE = 1 -> 0x0000FFFF with RAM_collision = 1.
  - Next read of addr 7 -> 0x0000FFFF in both modes.
- RD_LATENCY = 3: reads of addr 0, 1, 2 on consecutive edges (contents 0xA, 0xB, 0xC) -> three consecutive valid cycles, starting 3 cycles after the first read, carrying 0xA, 0xB, 0xC in order.
- RD_LATENCY = 3: issue 2 reads, assert RAM_rst one cycle later for 1 cycle -> no valid pulses appear; a read issued after reset returns correct data 3 cycles later.
- DEPTH = 600, ADDR_WIDTH = 10:
  - Write 0x12345678 to addr 700 -> RAM_addr_err pulses once and no memory word changes.
  - Read addr 700 -> valid with data 0 and a further RAM_addr_err pulse.
  - RAM_en = 0 with a read and a write requested -> no valid, no write, no error.
